// File: rtl/rename_register_file_pkg.sv
// Shared CPU constants for the rename stage: datapath and ROB tag widths plus
// the per-register rename entry layout.
package rename_register_file_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned TAG_W_DEF    = 5;
    localparam int unsigned NUM_RD_DEF   = 4;

    // Pending-producer state kept alongside each architectural register
    typedef struct packed {
        logic                 busy;
        logic [TAG_W_DEF-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/rrf_read_port.sv
// One combinational read port: register select plus same-cycle commit bypass.
module rrf_read_port
    import rename_register_file_pkg::*;
#(
    parameter  int unsigned XLEN     = XLEN_DEF,
    parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter  int unsigned TAG_W    = TAG_W_DEF,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]       addr_i,
    input  logic [XLEN-1:0]     val_i [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy_i,
    input  logic [TAG_W-1:0]    tag_i [NUM_REGS],
    input  logic                byp_en_i,
    input  logic [AW-1:0]       cmt_addr_i,
    input  logic [TAG_W-1:0]    cmt_tag_i,
    input  logic [XLEN-1:0]     cmt_data_i,
    output logic [XLEN-1:0]     data_o,
    output logic                busy_o,
    output logic [TAG_W-1:0]    tag_o
);

    logic hit;

    assign hit = byp_en_i && (addr_i == cmt_addr_i) && busy_i[addr_i]
                 && (tag_i[addr_i] == cmt_tag_i);

    // Bypass only fires when the commit retires the producer we are waiting on
    always_comb begin
        data_o = val_i[addr_i];
        busy_o = busy_i[addr_i];
        tag_o  = tag_i[addr_i];
        if (hit) begin
            data_o = cmt_data_i;
            busy_o = 1'b0;
        end
        if (addr_i == '0) begin
            data_o = '0;
            busy_o = 1'b0;
        end
        if (!busy_o) begin
            tag_o = '0;
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register busy/ROB-tag rename state,
// commit write-back, flush recovery and NUM_RD bypassed read ports.
module rename_register_file
    import rename_register_file_pkg::*;
#(
    parameter  int unsigned XLEN     = XLEN_DEF,
    parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter  int unsigned TAG_W    = TAG_W_DEF,
    parameter  int unsigned NUM_RD   = NUM_RD_DEF,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy_i,
    input  logic                    flush_i,
    input  logic [NUM_RD*AW-1:0]    rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]       rd_busy_o,
    output logic [NUM_RD*TAG_W-1:0] rd_tag_o,
    input  logic                    ren_en_i,
    input  logic [AW-1:0]           ren_addr_i,
    input  logic [TAG_W-1:0]        ren_tag_i,
    input  logic                    cmt_en_i,
    input  logic [AW-1:0]           cmt_addr_i,
    input  logic [TAG_W-1:0]        cmt_tag_i,
    input  logic [XLEN-1:0]         cmt_data_i,
    output logic [AW:0]             busy_count_o
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]     val_q [NUM_REGS];
    logic [XLEN-1:0]     val_d [NUM_REGS];
    logic [TAG_W-1:0]    tag_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                cmt_fire;
    logic                ren_fire;
    logic                cmt_match;

    assign cmt_fire  = cmt_en_i && rdy_i && !rst && (cmt_addr_i != '0);
    assign ren_fire  = ren_en_i && rdy_i && !flush_i && (ren_addr_i != '0);
    assign cmt_match = busy_q[cmt_addr_i] && (tag_q[cmt_addr_i] == cmt_tag_i);

    // Commit first, then flush, then rename so a same-cycle rename owns busy/tag
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (cmt_fire) begin
            val_d[cmt_addr_i] = cmt_data_i;
            if (cmt_match) begin
                busy_d[cmt_addr_i] = 1'b0;
            end
        end
        if (rdy_i && flush_i) begin
            busy_d = '0;
        end
        if (ren_fire) begin
            busy_d[ren_addr_i] = 1'b1;
            tag_d[ren_addr_i]  = ren_tag_i;
        end
        count_d = CW'($countones(busy_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '{default: '0};
            tag_q   <= '{default: '0};
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            val_q   <= val_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count_o = count_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rrf_read_port #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .TAG_W    (TAG_W)
        ) u_port (
            .addr_i     (rd_addr_i[p*AW +: AW]),
            .val_i      (val_q),
            .busy_i     (busy_q),
            .tag_i      (tag_q),
            .byp_en_i   (cmt_fire),
            .cmt_addr_i (cmt_addr_i),
            .cmt_tag_i  (cmt_tag_i),
            .cmt_data_i (cmt_data_i),
            .data_o     (rd_data_o[p*XLEN +: XLEN]),
            .busy_o     (rd_busy_o[p]),
            .tag_o      (rd_tag_o[p*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Vector-table bench for rename_register_file with a queue of expected read results.
module tb_rename_register_file;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TW   = 5;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 4;

    logic                  clk;
    logic                  rst;
    logic                  rdy;
    logic                  flush;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NRD*TW-1:0]     rd_tag;
    logic                  ren_en;
    logic [AW-1:0]         ren_addr;
    logic [TW-1:0]         ren_tag;
    logic                  cmt_en;
    logic [AW-1:0]         cmt_addr;
    logic [TW-1:0]         cmt_tag;
    logic [XLEN-1:0]       cmt_data;
    logic [AW:0]           busy_count;

    rename_register_file dut (
        .clk          (clk),
        .rst          (rst),
        .rdy_i        (rdy),
        .flush_i      (flush),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .rd_tag_o     (rd_tag),
        .ren_en_i     (ren_en),
        .ren_addr_i   (ren_addr),
        .ren_tag_i    (ren_tag),
        .cmt_en_i     (cmt_en),
        .cmt_addr_i   (cmt_addr),
        .cmt_tag_i    (cmt_tag),
        .cmt_data_i   (cmt_data),
        .busy_count_o (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rs, rd, fl, re;
        logic [4:0]  ra, rt;
        logic        ce;
        logic [4:0]  ca, ct;
        logic [31:0] cd;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        b0;
        logic [4:0]  t0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        b1;
        logic [4:0]  t1;
        logic [5:0]  cnt;
    } vec_t;

    typedef struct packed {
        logic [3:0][31:0] data;
        logic [3:0]       busy;
        logic [3:0][4:0]  tag;
        logic [5:0]       cnt;
        logic [15:0]      id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t row(input bit rs, rd, fl, re, input int ra, rt,
                                 input bit ce, input int ca, ct, input logic [31:0] cd,
                                 input int a0, input logic [31:0] d0, input bit b0, input int t0,
                                 input int a1, input logic [31:0] d1, input bit b1, input int t1,
                                 input int cnt);
        vec_t v;
        v.rs = rs; v.rd = rd; v.fl = fl; v.re = re;
        v.ra = 5'(ra); v.rt = 5'(rt);
        v.ce = ce; v.ca = 5'(ca); v.ct = 5'(ct); v.cd = cd;
        v.a0 = 5'(a0); v.d0 = d0; v.b0 = b0; v.t0 = 5'(t0);
        v.a1 = 5'(a1); v.d1 = d1; v.b1 = b1; v.t1 = 5'(t1);
        v.cnt = 6'(cnt);
        return v;
    endfunction

    task automatic check(input string nm, input int id, input int port,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d port %0d: got 0x%0h expected 0x%0h",
                     nm, id, port, act, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        for (int p = 0; p < 4; p++) begin
            check("rd_data", int'(e.id), p, rd_data[p*32 +: 32], e.data[p]);
            check("rd_busy", int'(e.id), p, 32'(rd_busy[p]), 32'(e.busy[p]));
            if (e.busy[p]) check("rd_tag", int'(e.id), p, 32'(rd_tag[p*5 +: 5]), 32'(e.tag[p]));
        end
        check("busy_count", int'(e.id), -1, 32'(busy_count), 32'(e.cnt));
    endtask

    // Drive one cycle at the falling edge, sample combinational reads before the rising edge
    task automatic apply(input vec_t v, input int id);
        exp_t e;
        rst = v.rs; rdy = v.rd; flush = v.fl;
        ren_en = v.re; ren_addr = v.ra; ren_tag = v.rt;
        cmt_en = v.ce; cmt_addr = v.ca; cmt_tag = v.ct; cmt_data = v.cd;
        rd_addr = {v.a1, v.a0, v.a1, v.a0};
        e.data = {v.d1, v.d0, v.d1, v.d0};
        e.busy = {v.b1, v.b0, v.b1, v.b0};
        e.tag  = {v.t1, v.t0, v.t1, v.t0};
        e.cnt  = v.cnt;
        e.id   = 16'(id);
        sb.push_back(e);
        #2;
        compare_front();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        ren_en = 1'b0; ren_addr = '0; ren_tag = '0;
        cmt_en = 1'b0; cmt_addr = '0; cmt_tag = '0; cmt_data = '0;
        rd_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Post-reset sweep of all 32 registers across the four ports
        for (int blk = 0; blk < 8; blk++) begin
            rd_addr = {5'(4*blk+3), 5'(4*blk+2), 5'(4*blk+1), 5'(4*blk)};
            e = '0;
            e.id = 16'(1000 + blk);
            sb.push_back(e);
            #2;
            compare_front();
            @(negedge clk);
        end

        //            rs rd fl re ra rt  ce ca ct cd            a0 d0           b0 t0  a1 d1           b1 t1  cnt
        tbl.push_back(row(0,1,0, 1,5,3,  0,0,0,32'h0,          5,32'h0,       0,0,   0,32'h0,       0,0,   0));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,          5,32'h0,       1,3,   7,32'h0,       0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  1,5,3,32'hDEADBEEF,   5,32'hDEADBEEF,0,0,   6,32'h0,       0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,          5,32'hDEADBEEF,0,0,   0,32'h0,       0,0,   0));
        tbl.push_back(row(0,1,0, 1,7,2,  0,0,0,32'h0,          7,32'h0,       0,0,   5,32'hDEADBEEF,0,0,   0));
        tbl.push_back(row(0,1,0, 1,7,9,  0,0,0,32'h0,          7,32'h0,       1,2,   0,32'h0,       0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  1,7,2,32'h11,         7,32'h0,       1,9,   5,32'hDEADBEEF,0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,          7,32'h11,      1,9,   5,32'hDEADBEEF,0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  1,7,9,32'h22,         7,32'h22,      0,0,   0,32'h0,       0,0,   1));
        tbl.push_back(row(0,1,0, 1,4,6,  1,4,1,32'h55,         4,32'h0,       0,0,   7,32'h22,      0,0,   0));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,          4,32'h55,      1,6,   7,32'h22,      0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  1,4,1,32'h66,         4,32'h55,      1,6,   0,32'h0,       0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,          4,32'h66,      1,6,   0,32'h0,       0,0,   1));
        for (int i = 1; i <= 10; i++)
            tbl.push_back(row(0,1,0, 1,i,i, 0,0,0,32'h0,       0,32'h0,       0,0,  12,32'h0,       0,0,  (i <= 4) ? i : i-1));
        tbl.push_back(row(0,1,1, 1,11,11,1,3,5,32'h77,         3,32'h0,       1,3,  10,32'h0,       1,10, 10));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,          3,32'h77,      0,0,  11,32'h0,       0,0,   0));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,          4,32'h66,      0,0,  10,32'h0,       0,0,   0));
        tbl.push_back(row(0,1,0, 1,0,7,  1,0,0,32'hFFFF,       0,32'h0,       0,0,   0,32'h0,       0,0,   0));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,          0,32'h0,       0,0,   1,32'h0,       0,0,   0));
        tbl.push_back(row(0,1,0, 1,12,12,0,0,0,32'h0,         12,32'h0,       0,0,  13,32'h0,       0,0,   0));
        tbl.push_back(row(0,0,0, 1,13,13,1,12,12,32'hAB,      12,32'h0,       1,12, 13,32'h0,       0,0,   1));
        tbl.push_back(row(0,0,1, 0,0,0,  0,0,0,32'h0,         12,32'h0,       1,12, 13,32'h0,       0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,         12,32'h0,       1,12, 13,32'h0,       0,0,   1));
        tbl.push_back(row(1,1,0, 1,14,1, 1,12,12,32'h99,      12,32'h0,       1,12,  7,32'h22,      0,0,   1));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,         12,32'h0,       0,0,   5,32'h0,       0,0,   0));
        tbl.push_back(row(0,1,0, 0,0,0,  0,0,0,32'h0,         14,32'h0,       0,0,   7,32'h0,       0,0,   0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rename_register_file.md
RENAME_REGISTER_FILE -- requirements
Module: rename_register_file

Interface
REQ-001 Parameter XLEN, default 32, architectural data width in bits.
REQ-002 Parameter NUM_REGS, default 32, architectural register count (power of 2); AW = log2(NUM_REGS).
REQ-003 Parameter TAG_W, default 5, width of a reorder-buffer tag.
REQ-004 Parameter NUM_RD, default 4, number of independent read ports.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rdy  in  1  global enable; low freezes all state (reads stay live).
REQ-008 flush  in  1  misprediction flush; clears all pending-rename state.
REQ-009 rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW].
REQ-010 rd_data  out  NUM_RD*XLEN  per-port register value.
REQ-011 rd_busy  out  NUM_RD  per-port: register awaits an in-flight producer.
REQ-012 rd_tag  out  NUM_RD*TAG_W  per-port producer tag; valid only when rd_busy set.
REQ-013 ren_en  in  1  rename request: mark ren_addr busy with ren_tag.
REQ-014 ren_addr  in  AW  destination register being renamed.
REQ-015 ren_tag  in  TAG_W  ROB tag of the new producer.
REQ-016 cmt_en  in  1  commit request from ROB head.
REQ-017 cmt_addr  in  AW  committed destination register.
REQ-018 cmt_tag  in  TAG_W  ROB tag of committing instruction.
REQ-019 cmt_data  in  XLEN  committed value.
REQ-020 busy_count  out  AW+1  registered count of busy registers.

Function
REQ-021 Per register, storage SHALL be value[XLEN], busy[1], tag[TAG_W].
REQ-022 Reads SHALL be combinational, zero latency, all ports independent.
REQ-023 Commit bypass: if cmt_en && rdy && !rst, rd_addr==cmt_addr!=0, busy set and stored tag==cmt_tag, port SHALL return cmt_data with rd_busy=0 the same cycle.
REQ-024 Rename bypass SHALL NOT exist; a same-cycle rename becomes visible next cycle.
REQ-025 On commit, value SHALL be written with cmt_data unconditionally (cmt_addr!=0).
REQ-026 On commit, busy SHALL clear only when stored tag==cmt_tag; otherwise busy/tag unchanged (younger producer pending).
REQ-027 On rename (ren_addr!=0, !flush), busy SHALL set and tag SHALL load ren_tag.
REQ-028 Rename and commit to the same register in one cycle: value from commit, busy=1, tag=ren_tag (rename wins).
REQ-029 Flush SHALL clear every busy bit; rename that cycle is ignored; commit value write that cycle still occurs.
REQ-030 Register 0 SHALL always read value 0, busy 0, tag 0; writes/renames to it ignored.
REQ-031 busy_count SHALL equal population count of busy bits after each edge; range 0..NUM_REGS-1.
REQ-032 rdy low SHALL suppress rename, commit, flush state changes and the commit bypass.

Reset
REQ-033 rst SHALL clear all values, busy bits, tags and busy_count to 0 at the next edge, overriding rdy, flush, rename, commit.
REQ-034 Reset asserted mid-sequence SHALL discard any same-cycle rename or commit.

Structure
REQ-035 XLEN/TAG_W defaults and a tag-entry typedef {busy, tag} SHALL live in the shared CPU package with other ROB-width constants.
REQ-036 One sub-module rrf_read_port (per-port mux plus commit-bypass compare) SHALL be instantiated NUM_RD times via generate.
REQ-037 Storage SHALL be a single clocked process; no combinational writes to state.

Verification
REQ-038 Reset, then read all 32 regs on 4 ports -> data 0, busy 0, busy_count 0.
REQ-039 Rename x5 tag 3; next cycle read x5 -> busy 1, tag 3, busy_count 1; commit x5 tag 3 data 0xDEADBEEF -> same-cycle read 0xDEADBEEF busy 0; next cycle busy_count 0.
REQ-040 Rename x7 tag 2, then x7 tag 9; commit x7 tag 2 data 0x11 -> value 0x11, busy 1, tag 9.
REQ-041 Same cycle rename x4 tag 6 and commit x4 tag 1 data 0x55 -> next cycle value 0x55, busy 1, tag 6.
REQ-042 Rename x1..x10, assert flush with rename x11 and commit x3 data 0x77 -> all busy 0, x3=0x77, x11 not busy, busy_count 0.
REQ-043 Rename/commit x0 data 0xFFFF, and any op with rdy=0 -> x0 reads 0 not busy; no state changes while rdy=0.
